// File: rtl/covemb_pkg.sv
// ---------------------------------------------------------------------------
// covemb_pkg
// Shared definitions for the stimulus generator slice.
//   state_t    : run-control states of stim_gen (idle, generating, finished)
//   LFSR_POLY  : Galois feedback mask for the 32-bit payload LFSR
//   lfsr_step  : one Galois shift of the LFSR (right shift, xor mask on lsb)
//   seed_fix   : maps the all-zero seed (a lock-up state) onto 32'h1
// ---------------------------------------------------------------------------
package covemb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Galois form: shift toward bit 0 and fold the polynomial back in
  // whenever a 1 falls out of the low end.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so that seed is remapped.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// ---------------------------------------------------------------------------
// stim_lfsr
// 32-bit Galois LFSR used as the random source of stim_gen.
// Ports:
//   clk      in   clock, state updates on rising edge
//   rst      in   asynchronous active-high reset, loads seed
//   seed     in   [31:0] value loaded while rst is high (must be non-zero)
//   advance  in   step the register by one position this cycle
//   value    out  [31:0] current LFSR contents
// ---------------------------------------------------------------------------
module stim_lfsr
  import covemb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);

  // The register only moves when the owner asks, so the sequence position
  // is tied to events (start, accepted transfers) rather than to time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/stim_gen.sv
// ---------------------------------------------------------------------------
// stim_gen
// Valid/ready stimulus source. After a start it emits NUM_TXN payloads
// (or an endless stream when NUM_TXN is 0) with a fixed command, an address
// that is either pseudo-random or a wrapping sweep, and pseudo-random data,
// all confined to the configured inclusive ranges.
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   begin a run (honoured only when not generating)
//   cfg_mode  in   0 = random address, 1 = sweep address (sampled with start)
//   valid     out  payload valid
//   ready     in   sink accepts payload
//   cmd       out  [CMD_W-1:0]  command, CMD_VAL while valid, else 0
//   adr       out  [ADR_W-1:0]  address, 0 while not valid
//   data      out  [DATA_W-1:0] data, 0 while not valid
//   busy      out  high while generating
//   done      out  high after the last transfer until the next start
//   txn_cnt   out  [15:0] accepted transfers this run, saturating
// ---------------------------------------------------------------------------
module stim_gen
  import covemb_pkg::*;
#(
  parameter int unsigned CMD_W    = 2,
  parameter int unsigned ADR_W    = 4,
  parameter int unsigned DATA_W   = 3,
  parameter int unsigned CMD_VAL  = 3,
  parameter int unsigned ADR_MIN  = 5,
  parameter int unsigned ADR_MAX  = 15,
  parameter int unsigned DATA_MIN = 0,
  parameter int unsigned DATA_MAX = 7,
  parameter logic [31:0] SEED     = 32'h1,
  parameter int unsigned NUM_TXN  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cfg_mode,
  output logic              valid,
  input  logic              ready,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADR_W-1:0]  adr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       txn_cnt
);

  localparam int unsigned ADR_SPAN  = ADR_MAX - ADR_MIN + 1;
  localparam int unsigned DATA_SPAN = DATA_MAX - DATA_MIN + 1;

  state_t            state;
  state_t            next_state;
  logic              start_take;
  logic              xfer;
  logic              count_hit;
  logic              mode;
  logic [ADR_W-1:0]  sweep_adr;
  logic [15:0]       cnt;
  logic [31:0]       lfsr;

  // The LFSR steps once when a run is launched and once per accepted
  // transfer, so a stalled payload keeps its random fields unchanged.
  stim_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed    (seed_fix(SEED)),
    .advance (start_take | xfer),
    .value   (lfsr)
  );

  // True when the transfer happening this cycle would be the last one of
  // a bounded run. An unbounded run (NUM_TXN == 0) never hits.
  always_comb begin
    count_hit = (NUM_TXN != 0) && ((32'(cnt) + 32'd1) == 32'(NUM_TXN));
  end

  // Run-control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control outputs. valid is simply "in GEN", which makes
  // it drop on the same edge that moves to DONE after the final transfer.
  always_comb begin
    next_state = state;
    valid      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_take = 1'b0;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_take = 1'b1;
          next_state = ST_GEN;
        end
      end
      ST_GEN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready) begin
          xfer = 1'b1;
          if (count_hit) begin
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          start_take = 1'b1;
          next_state = ST_GEN;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Per-run bookkeeping: the address mode is captured at launch, the sweep
  // pointer restarts at ADR_MIN each run, and the counter saturates rather
  // than wrapping so long unbounded runs still read as "very many".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode      <= 1'b0;
      sweep_adr <= ADR_W'(ADR_MIN);
      cnt       <= 16'h0;
    end else if (start_take) begin
      mode      <= cfg_mode;
      sweep_adr <= ADR_W'(ADR_MIN);
      cnt       <= 16'h0;
    end else if (xfer) begin
      cnt       <= (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      sweep_adr <= (sweep_adr == ADR_W'(ADR_MAX)) ? ADR_W'(ADR_MIN)
                                                  : sweep_adr + ADR_W'(1);
    end
  end

  // Payload fields are derived from registered state only, so they are
  // stable for as long as the sink stalls. Everything reads zero while
  // no payload is offered.
  always_comb begin
    cmd  = '0;
    adr  = '0;
    data = '0;
    if (valid) begin
      cmd  = CMD_W'(CMD_VAL);
      adr  = mode ? sweep_adr
                  : ADR_W'(32'(ADR_MIN) + (32'(lfsr[15:0]) % 32'(ADR_SPAN)));
      data = DATA_W'(32'(DATA_MIN) + (32'(lfsr[31:16]) % 32'(DATA_SPAN)));
    end
  end

  assign txn_cnt = cnt;

endmodule

// File: tb/tb_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_stim_gen
// Self-checking bench for stim_gen. Instance u_a uses all defaults and is
// checked every cycle against a transaction-level reference model; u_b uses
// NUM_TXN=23 with SEED=0 and is checked against a precomputed sweep table.
// ---------------------------------------------------------------------------
module tb_stim_gen;

  logic        clk = 1'b0;
  logic        rst;

  logic        startA, modeA, readyA;
  logic        validA, busyA, doneA;
  logic [1:0]  cmdA;
  logic [3:0]  adrA;
  logic [2:0]  dataA;
  logic [15:0] cntA;

  logic        startB, modeB, readyB;
  logic        validB, busyB, doneB;
  logic [1:0]  cmdB;
  logic [3:0]  adrB;
  logic [2:0]  dataB;
  logic [15:0] cntB;

  logic [27:0] packA;
  logic [27:0] packB;

  int nVec  = 0;
  int nMiss = 0;

  // Reference model state for u_a: phase 0 = idle, 1 = running, 2 = finished
  logic [31:0] mLfsr;
  int          mPhase;
  logic        mMode;
  int          mCnt;

  typedef struct {
    logic        start;
    logic        ready;
    logic [27:0] exp;
  } vecB_t;

  typedef struct {
    logic        start;
    logic        ready;
    logic        mode;
    logic        expValid;
    logic        expBusy;
    logic        expDone;
    logic [15:0] expCnt;
  } vecA_t;

  vecB_t tblB[24];
  vecA_t tblA[7];

  always #5 clk = ~clk;

  stim_gen u_a (
    .clk(clk), .rst(rst), .start(startA), .cfg_mode(modeA),
    .valid(validA), .ready(readyA), .cmd(cmdA), .adr(adrA), .data(dataA),
    .busy(busyA), .done(doneA), .txn_cnt(cntA)
  );

  stim_gen #(.NUM_TXN(23), .SEED(32'h0)) u_b (
    .clk(clk), .rst(rst), .start(startB), .cfg_mode(modeB),
    .valid(validB), .ready(readyB), .cmd(cmdB), .adr(adrB), .data(dataB),
    .busy(busyB), .done(doneB), .txn_cnt(cntB)
  );

  assign packA = {validA, busyA, doneA, cmdA, adrA, dataA, cntA};
  assign packB = {validB, busyB, doneB, cmdB, adrB, dataB, cntB};

  // Galois LFSR with mask 32'h80200003 shifting toward bit 0
  function automatic logic [31:0] lfsrNext(input logic [31:0] v);
    logic [31:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 32'h80200003;
    return s;
  endfunction

  // What u_a should show given the model: address is ADR_MIN plus either
  // the transfer index modulo the range (sweep) or the low LFSR half
  // modulo the range (random); data is the high half modulo 8.
  function automatic logic [27:0] modelOutA();
    logic       v;
    logic [1:0] c;
    logic [3:0] a;
    logic [2:0] d;
    v = (mPhase == 1);
    c = 2'd0;
    a = 4'd0;
    d = 3'd0;
    if (v) begin
      c = 2'd3;
      a = mMode ? 4'(5 + (mCnt % 11)) : 4'(5 + (int'(mLfsr[15:0]) % 11));
      d = 3'(int'(mLfsr[31:16]) % 8);
    end
    return {v, v, (mPhase == 2), c, a, d, 16'(mCnt)};
  endfunction

  task automatic modelReset();
    mLfsr  = 32'h1;
    mPhase = 0;
    mMode  = 1'b0;
    mCnt   = 0;
  endtask

  task automatic modelStep(input logic s, input logic r, input logic m);
    if (mPhase != 1) begin
      if (s) begin
        mPhase = 1;
        mLfsr  = lfsrNext(mLfsr);
        mMode  = m;
        mCnt   = 0;
      end
    end else if (r) begin
      mCnt  = mCnt + 1;
      mLfsr = lfsrNext(mLfsr);
      if (mCnt == 100) mPhase = 2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive u_a for one clock (called just after a falling edge), advance the
  // model on the rising edge and compare on the following falling edge.
  task automatic applyStimulus(input logic s, input logic r, input logic m);
    startA = s;
    readyA = r;
    modeA  = m;
    @(posedge clk);
    modelStep(s, r, m);
    @(negedge clk);
    startA = 1'b0;
    checkOutput("A-cycle", 64'(packA), 64'(modelOutA()));
  endtask

  // Assert reset between clock edges and expect outputs to clear at once.
  task automatic asyncReset();
    #1 rst = 1'b1;
    #1 checkOutput("async-reset", 64'(packA), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t exceeded, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] l;

    // Sweep table for u_b: starts at 5, wraps 15 -> 5, ends after 23.
    // SEED=0 must behave as SEED=1, so the data column uses seed 1.
    l = lfsrNext(32'h1);
    tblB[0].start = 1'b1;
    tblB[0].ready = 1'b1;
    tblB[0].exp   = {1'b1, 1'b1, 1'b0, 2'd3, 4'd5, 3'(int'(l[31:16]) % 8), 16'd0};
    for (int i = 1; i < 24; i++) begin
      l = lfsrNext(l);
      tblB[i].start = 1'b0;
      tblB[i].ready = 1'b1;
      if (i < 23)
        tblB[i].exp = {1'b1, 1'b1, 1'b0, 2'd3, 4'(5 + (i % 11)),
                       3'(int'(l[31:16]) % 8), 16'(i)};
      else
        tblB[i].exp = {1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 3'd0, 16'd23};
    end

    // Control-path table for u_a: idle, launch, transfer, stall, start and
    // mode change ignored mid-run, transfer.
    tblA[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tblA[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tblA[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tblA[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    tblA[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
    tblA[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    tblA[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};

    rst    = 1'b1;
    startA = 1'b0; modeA = 1'b0; readyA = 1'b0;
    startB = 1'b0; modeB = 1'b1; readyB = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset-A", 64'(packA), 64'd0);
    checkOutput("reset-B", 64'(packB), 64'd0);
    rst = 1'b0;

    $display("[TB] sweep run on NUM_TXN=23, SEED=0 instance");
    for (int i = 0; i < 24; i++) begin
      startB = tblB[i].start;
      readyB = tblB[i].ready;
      @(posedge clk);
      @(negedge clk);
      startB = 1'b0;
      checkOutput($sformatf("B-row%0d", i), 64'(packB), 64'(tblB[i].exp));
    end
    repeat (3) @(negedge clk);
    checkOutput("B-done-hold", 64'(packB), 64'({1'b0, 1'b0, 1'b1, 25'd23}));

    $display("[TB] control table on default instance");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tblA[i].start, tblA[i].ready, tblA[i].mode);
      checkOutput($sformatf("A-tbl%0d", i), 64'({validA, busyA, doneA, cntA}),
                  64'({tblA[i].expValid, tblA[i].expBusy, tblA[i].expDone,
                       tblA[i].expCnt}));
    end

    $display("[TB] finish first run with ready held high");
    for (int k = 0; k < 300 && mPhase == 1; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("A-run1-end", 64'({validA, doneA, cntA}), 64'({1'b0, 1'b1, 16'd100}));

    $display("[TB] restart from DONE, 4-cycle stall, then random ready");
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("A-restart-cnt", 64'({validA, doneA, cntA}), 64'({1'b1, 1'b0, 16'd0}));
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 600 && mPhase == 1; k++)
      applyStimulus(1'(($urandom_range(0, 3) == 0)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));

    $display("[TB] mid-run reset and replay");
    asyncReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("A-pre-reset-cnt", 64'(cntA), 64'd10);
    asyncReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int k = 0; k < 800; k++)
      applyStimulus(1'(($urandom_range(0, 7) == 0)), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
